// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus bundle: hazard/redirect controls, instruction memory port
// and the IF/ID register outputs seen by decode.
interface instr_fetch_stage_if #(
    parameter int PC_W   = 9,
    parameter int INST_W = 32
);
    logic              stall;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic [PC_W-1:0]   if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_valid;
    logic              halted;
    logic [31:0]       inst_count;

    modport master (
        input  stall,
        input  redirect,
        input  redirect_pc,
        input  imem_rdata,
        output imem_addr,
        output if_pc,
        output if_inst,
        output if_valid,
        output halted,
        output inst_count
    );

    modport slave (
        output stall,
        output redirect,
        output redirect_pc,
        output imem_rdata,
        input  imem_addr,
        input  if_pc,
        input  if_inst,
        input  if_valid,
        input  halted,
        input  inst_count
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// IF stage with IF/ID register: PC ownership, stall/redirect handling,
// HALT detection and delivered-instruction counter.
module instr_fetch_stage #(
    parameter int                PC_W     = 9,
    parameter int                INST_W   = 32,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [INST_W-1:0] NOP      = 32'h00000013
) (
    input logic                 clk,
    input logic                 reset,
    instr_fetch_stage_if.master bus
);

    typedef enum logic {
        RUN,
        HALTED
    } state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              valid;
    } if_id_t;

    localparam logic [6:0] HALT_OP = 7'b1111111;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    if_id_t          ifid_q, ifid_d;
    logic            halted_q, halted_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            is_halt;

    assign is_halt = (bus.imem_rdata[6:0] == HALT_OP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            ifid_q   <= '{pc: '0, inst: NOP, valid: 1'b0};
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ifid_q   <= ifid_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ifid_d   = ifid_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        // Redirect wins over stall so a wrong-path HALT is always cancelled.
        if (bus.redirect) begin
            pc_d         = {bus.redirect_pc[PC_W-1:2], 2'b00};
            ifid_d.inst  = NOP;
            ifid_d.valid = 1'b0;
            state_d      = RUN;
            halted_d     = 1'b0;
        end else if (!bus.stall) begin
            unique case (state_q)
                RUN: begin
                    ifid_d.pc    = pc_q;
                    ifid_d.inst  = bus.imem_rdata;
                    ifid_d.valid = 1'b1;
                    cnt_d        = cnt_q + 32'd1;
                    if (is_halt) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_W'(4);
                    end
                end
                HALTED: begin
                    ifid_d.inst  = NOP;
                    ifid_d.valid = 1'b0;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.if_pc      = ifid_q.pc;
    assign bus.if_inst    = ifid_q.inst;
    assign bus.if_valid   = ifid_q.valid;
    assign bus.halted     = halted_q;
    assign bus.inst_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: straight-line, stall, halt,
// redirect, wrap and asynchronous reset.
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    logic [31:0] mem [128];

    instr_fetch_stage_if #(.PC_W(9), .INST_W(32)) bus ();

    instr_fetch_stage #(
        .PC_W    (9),
        .INST_W  (32),
        .RESET_PC(9'h000),
        .NOP     (NOP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_rdata = mem[bus.imem_addr[8:2]];

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag,
                           input logic [8:0]  pc,
                           input logic [8:0]  ipc,
                           input logic [31:0] inst,
                           input logic        vld,
                           input logic        hlt,
                           input logic [31:0] cnt);
        check({tag, ".pc"}, 32'(bus.imem_addr), 32'(pc));
        check({tag, ".if_pc"}, 32'(bus.if_pc), 32'(ipc));
        check({tag, ".if_inst"}, bus.if_inst, inst);
        check({tag, ".if_valid"}, 32'(bus.if_valid), 32'(vld));
        check({tag, ".halted"}, 32'(bus.halted), 32'(hlt));
        check({tag, ".count"}, bus.inst_count, cnt);
    endtask

    initial begin
        for (int i = 0; i < 128; i++)
            mem[i] = NOP | (32'(i) << 20);
        mem[3] = 32'h0000007F;

        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        reset           = 1'b1;
        #12;
        chk_all("reset", 9'h000, 9'h000, NOP, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;

        step();
        chk_all("seq0", 9'h004, 9'h000, 32'h00000013, 1'b1, 1'b0, 32'd1);
        step();
        chk_all("seq1", 9'h008, 9'h004, 32'h00100013, 1'b1, 1'b0, 32'd2);

        bus.stall = 1'b1;
        step();
        chk_all("stall0", 9'h008, 9'h004, 32'h00100013, 1'b1, 1'b0, 32'd2);
        step();
        chk_all("stall1", 9'h008, 9'h004, 32'h00100013, 1'b1, 1'b0, 32'd2);
        bus.stall = 1'b0;
        step();
        chk_all("seq2", 9'h00C, 9'h008, 32'h00200013, 1'b1, 1'b0, 32'd3);

        step();
        chk_all("halt_in", 9'h00C, 9'h00C, 32'h0000007F, 1'b1, 1'b1, 32'd4);
        bus.stall = 1'b1;
        step();
        chk_all("halt_stl", 9'h00C, 9'h00C, 32'h0000007F, 1'b1, 1'b1, 32'd4);
        bus.stall = 1'b0;
        step();
        chk_all("halt_nop", 9'h00C, 9'h00C, NOP, 1'b0, 1'b1, 32'd4);
        step();
        chk_all("halt_hold", 9'h00C, 9'h00C, NOP, 1'b0, 1'b1, 32'd4);

        bus.redirect    = 1'b1;
        bus.redirect_pc = 9'h020;
        step();
        bus.redirect = 1'b0;
        chk_all("unhalt", 9'h020, 9'h00C, NOP, 1'b0, 1'b0, 32'd4);
        step();
        chk_all("resume", 9'h024, 9'h020, 32'h00800013, 1'b1, 1'b0, 32'd5);

        bus.stall       = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 9'h041;
        step();
        bus.stall    = 1'b0;
        bus.redirect = 1'b0;
        chk_all("rdr_stl", 9'h040, 9'h020, NOP, 1'b0, 1'b0, 32'd5);
        step();
        chk_all("rdr_go", 9'h044, 9'h040, 32'h01000013, 1'b1, 1'b0, 32'd6);

        bus.redirect    = 1'b1;
        bus.redirect_pc = 9'h1F8;
        step();
        bus.redirect = 1'b0;
        chk_all("wrap_rdr", 9'h1F8, 9'h040, NOP, 1'b0, 1'b0, 32'd6);
        step();
        chk_all("wrap0", 9'h1FC, 9'h1F8, 32'h07E00013, 1'b1, 1'b0, 32'd7);
        step();
        chk_all("wrap1", 9'h000, 9'h1FC, 32'h07F00013, 1'b1, 1'b0, 32'd8);
        step();
        chk_all("wrap2", 9'h004, 9'h000, 32'h00000013, 1'b1, 1'b0, 32'd9);

        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 9'h000, 9'h000, NOP, 1'b0, 1'b0, 32'd0);
        #3;
        reset = 1'b0;
        step();
        chk_all("post_rst", 9'h004, 9'h000, 32'h00000013, 1'b1, 1'b0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
